button_conditioner: RTL and testbench

- Input front end for the counter/FSM subsystem, sitting directly upstream of the state machine that consumes `start`, `progressive` and `regressive`.
- Takes raw, asynchronous, bouncing board push-buttons and synchronises each one to `clk_100MHz`.
- Debounces each button independently.
- Produces a clean debounced level plus single-cycle press/release pulses per button.

---
 rtl/button_conditioner.sv | 129 ++++++++++++
 tb/tb_button_conditioner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : button_conditioner                                            |
// | Purpose  : Two-flop synchroniser, per-channel debounce and registered    |
// |            press/release pulse generation for raw board push-buttons.    |
// |            Optional auto-repeat on btn_press via `BTN_AUTOREPEAT_EN.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int              RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RPT_W     = $clog2(RPT_MAX) + 1;
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic             sync1_q;
        logic             sync2_q;
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        logic             rpt_hit;

        // Debounce: count consecutive disagreeing samples, accept on the last one
        always_comb begin
            stable_d  = stable_q;
            cnt_d     = '0;
            if (sync2_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            press_d   = (stable_d & ~stable_q) | rpt_hit;
            release_d = ~stable_d & stable_q;
        end

        // Synchroniser, stable level, counter and pulse registers
        always_ff @(posedge clk_100MHz) begin
            if (reset) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                stable_q  <= 1'b0;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= btn_raw[i];
                sync2_q   <= sync1_q;
                stable_q  <= stable_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt_q;
        logic [RPT_W-1:0] rpt_cnt_d;
        logic             rpt_on_q;
        logic             rpt_on_d;

        // Repeat timer: first pulse after the hold delay, then every period;
        // gated on the next level so a release edge never also repeats
        always_comb begin
            rpt_cnt_d = '0;
            rpt_on_d  = 1'b0;
            rpt_hit   = 1'b0;
            if (stable_q && stable_d) begin
                rpt_on_d  = rpt_on_q;
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                if (!rpt_on_q && (rpt_cnt_q == RPT_FIRST)) begin
                    rpt_hit   = 1'b1;
                    rpt_cnt_d = '0;
                    rpt_on_d  = 1'b1;
                end else if (rpt_on_q && (rpt_cnt_q == RPT_NEXT)) begin
                    rpt_hit   = 1'b1;
                    rpt_cnt_d = '0;
                end
            end
        end

        // Repeat timer registers
        always_ff @(posedge clk_100MHz) begin
            if (reset) begin
                rpt_cnt_q <= '0;
                rpt_on_q  <= 1'b0;
            end else begin
                rpt_cnt_q <= rpt_cnt_d;
                rpt_on_q  <= rpt_on_d;
            end
        end
`else
        assign rpt_hit = 1'b0;
`endif

        assign btn_level[i]   = stable_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_button_conditioner                                         |
// | Purpose  : Directed scoreboard bench for button_conditioner with a short |
// |            debounce window; auto-repeat steps under `BTN_AUTOREPEAT_EN.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_button_conditioner;

    localparam int NB  = 3;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic          clk_100MHz;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // Expected {level, press, release} after edge c
    task automatic push(input int c, input logic [2:0] lvl, input logic [2:0] prs,
                        input logic [2:0] rel, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = {lvl, prs, rel};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Advance one edge, sample 1 ns later, retire scoreboard entries due now
    task automatic tick();
        exp_t e;
        @(posedge clk_100MHz);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            assert ((e.cyc == cyc) && ({btn_level, btn_press, btn_release} === e.vec)) else begin
                bad++;
                $error("FAIL %s cyc=%0d due=%0d observed lvl/prs/rel=%b required=%b",
                       e.tag, cyc, e.cyc, {btn_level, btn_press, btn_release}, e.vec);
            end
        end
    endtask

    // Drive a new raw value held steady; acceptance lands DB+1 edges after the first sampling edge
    task automatic transition(input logic [2:0] new_raw, input logic [2:0] old_lvl,
                              input logic [2:0] new_lvl, input string tag);
        int t;
        t = cyc + 1;
        btn_raw = new_raw;
        for (int c = t; c < t + DB + 1; c++) push(c, old_lvl, 3'b000, 3'b000, {tag, "_wait"});
        push(t + DB + 1, new_lvl, new_lvl & ~old_lvl, old_lvl & ~new_lvl, {tag, "_edge"});
        push(t + DB + 2, new_lvl, 3'b000, 3'b000, {tag, "_after"});
        repeat (DB + 3) tick();
    endtask

    initial begin
        int t;
        int a;
        logic [2:0] prs;
        reset   = 1'b1;
        btn_raw = 3'b111;

        // Reset held with all buttons pressed: outputs stay low
        for (int c = 1; c <= 5; c++) push(c, 3'b000, 3'b000, 3'b000, "reset");
        repeat (5) tick();
        reset = 1'b0;

        // Buttons held through reset are re-accepted together as a fresh press
        transition(3'b111, 3'b000, 3'b111, "held_thru_reset");
        transition(3'b000, 3'b111, 3'b000, "release_all");

        // Clean press on channel 0
        transition(3'b001, 3'b000, 3'b001, "press0");

        // Channel 1 bounces 3 high / 1 low: never accepted, channel 0 undisturbed
        t = cyc + 1;
        for (int c = t; c < t + 28; c++) push(c, 3'b001, 3'b000, 3'b000, "bounce1");
        for (int r = 0; r < 5; r++) begin
            btn_raw[1] = 1'b1;
            repeat (3) tick();
            btn_raw[1] = 1'b0;
            tick();
        end
        repeat (8) tick();

        // Press and release channel 2 while channel 0 is held
        transition(3'b101, 3'b001, 3'b101, "press2");
        transition(3'b001, 3'b101, 3'b001, "release2");
        transition(3'b000, 3'b001, 3'b000, "release0");

        // Channels 0 and 2 rise together while channel 1 chatters every cycle
        t = cyc + 1;
        for (int c = t; c < t + DB + 1; c++) push(c, 3'b000, 3'b000, 3'b000, "simul_wait");
        push(t + DB + 1, 3'b101, 3'b101, 3'b000, "simul_edge");
        for (int c = t + DB + 2; c < t + 12; c++) push(c, 3'b101, 3'b000, 3'b000, "simul_hold");
        for (int k = 0; k < 12; k++) begin
            btn_raw = {1'b1, (k % 2 == 0), 1'b1};
            tick();
        end
        btn_raw[1] = 1'b0;
        transition(3'b000, 3'b101, 3'b000, "simul_release");

`ifdef BTN_AUTOREPEAT_EN
        // Hold channel 0 for 60 cycles: press at acceptance, +RD, then every RP
        t = cyc + 1;
        a = t + DB + 1;
        for (int c = t; c < t + 60 + DB + 1; c++) begin
            prs = 3'b000;
            if (c == a || (c >= a + RD && ((c - a - RD) % RP) == 0)) prs = 3'b001;
            push(c, (c >= a) ? 3'b001 : 3'b000, prs, 3'b000, "repeat_hold");
        end
        push(t + 60 + DB + 1, 3'b000, 3'b000, 3'b001, "repeat_release");
        for (int c = t + 60 + DB + 2; c < t + 76; c++) push(c, 3'b000, 3'b000, 3'b000, "repeat_quiet");
        btn_raw = 3'b001;
        repeat (60) tick();
        btn_raw = 3'b000;
        repeat (16) tick();
`endif

        // Idle tail
        t = cyc + 1;
        for (int c = t; c < t + 4; c++) push(c, 3'b000, 3'b000, 3'b000, "idle");
        repeat (4) tick();

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d entries left required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
